// File: rtl/shuffle_gen_pkg.sv
// Shared types and constants for the Fisher-Yates shuffle generator.
// Build option: SHUFFLE_LFSR_FREERUN_EN (free-running LFSR while idle).
package shuffle_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DRAW,
    SWAP,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Smallest all-ones value >= i.
  function automatic logic [15:0] mask_for(input logic [15:0] i);
    logic [15:0] m;
    m = i;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

// File: rtl/shuffle_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR with load and step enable.
// Load has priority over step.
module lfsr16
  import shuffle_gen_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1,
  parameter logic [15:0] TAPS      = LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_step;

  always_comb begin
    q_step = {1'b0, q[15:1]};
    if (q[0]) q_step = q_step ^ TAPS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q_step;
    end
  end

endmodule

// File: rtl/shuffle_gen.sv
// In-place Fisher-Yates permutation of 0..N-1 driven by a 16-bit LFSR.
// Build option: SHUFFLE_LFSR_FREERUN_EN (LFSR steps every idle cycle).
module shuffle_gen
  import shuffle_gen_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          N            = 16,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        seed,
  output logic               busy,
  output logic               done,
  output logic [N*WIDTH-1:0] data_out
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx_i;
  logic [IW-1:0]  idx_j;
  logic [IW-1:0]  j_nxt;
  logic [WIDTH-1:0] arr [N];

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_val;
  logic        lfsr_en;
  logic        lfsr_ld;

  logic [15:0] i_ext;
  logic [15:0] r;
  logic [15:0] j_ext;

  lfsr16 #(
    .RESET_VAL (DEFAULT_SEED),
    .TAPS      (LFSR_TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (lfsr_en),
    .load     (lfsr_ld),
    .load_val (lfsr_val),
    .q        (lfsr_q)
  );

  // Fold draws above i back into 0..i so each draw takes one cycle.
  always_comb begin
    i_ext = 16'(idx_i);
    r     = lfsr_q & mask_for(i_ext);
    j_ext = (r > i_ext) ? (r - i_ext - 16'd1) : r;
    j_nxt = IW'(j_ext);
  end

  always_comb begin
    state_nxt = state;
    lfsr_en   = 1'b0;
    lfsr_ld   = 1'b0;
    lfsr_val  = (seed == 16'd0) ? DEFAULT_SEED : seed;
    unique case (state)
      IDLE: begin
`ifdef SHUFFLE_LFSR_FREERUN_EN
        lfsr_en  = 1'b1;
        lfsr_val = seed;
        lfsr_ld  = start && (seed != 16'd0);
`else
        lfsr_ld  = start;
`endif
        if (start) state_nxt = INIT;
      end
      INIT: state_nxt = DRAW;
      DRAW: begin
        lfsr_en   = 1'b1;
        state_nxt = SWAP;
      end
      SWAP: begin
        if (idx_i == IW'(1)) state_nxt = DONE;
        else                 state_nxt = DRAW;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx_i <= '0;
      idx_j <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) idx_i <= IW'(N - 1);
      if (state == DRAW) idx_j <= j_nxt;
      if (state == SWAP) idx_i <= idx_i - IW'(1);
    end
  end

  for (genvar e = 0; e < N; e++) begin : g_elem
    logic hit_i;
    logic hit_j;

    assign hit_i = (idx_i == IW'(e));
    assign hit_j = (idx_j == IW'(e));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        arr[e] <= WIDTH'(e);
      end else if (state == INIT) begin
        arr[e] <= WIDTH'(e);
      end else if (state == SWAP) begin
        if (hit_i)      arr[e] <= arr[idx_j];
        else if (hit_j) arr[e] <= arr[idx_i];
      end
    end

    assign data_out[e*WIDTH +: WIDTH] = arr[e];
  end

  assign busy = (state == INIT) || (state == DRAW) || (state == SWAP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shuffle_gen.sv
// Directed bench for shuffle_gen with a reference Fisher-Yates model.
// Build option: SHUFFLE_LFSR_FREERUN_EN selects the free-run checks.
module tb_shuffle_gen;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   seed = 16'd0;
  logic          busy;
  logic          done;
  logic [BW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  shuffle_gen #(
    .WIDTH        (W),
    .N            (N),
    .DEFAULT_SEED (16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] identity();
    logic [BW-1:0] v;
    v = '0;
    for (int e = 0; e < N; e++) v[e*W +: W] = W'(e);
    return v;
  endfunction

  function automatic logic [BW-1:0] model(input logic [15:0] s);
    logic [15:0] lf;
    logic [15:0] m;
    logic [15:0] rr;
    int          j;
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    logic [BW-1:0] v;
    lf = (s == 16'd0) ? 16'hACE1 : s;
    for (int e = 0; e < N; e++) a[e] = W'(e);
    for (int i = N - 1; i >= 1; i--) begin
      m = 16'd1;
      while (m < 16'(i)) m = (m << 1) | 16'd1;
      rr = lf & m;
      j  = (int'(rr) > i) ? int'(rr) - i - 1 : int'(rr);
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
      t    = a[i];
      a[i] = a[j];
      a[j] = t;
    end
    v = '0;
    for (int e = 0; e < N; e++) v[e*W +: W] = a[e];
    return v;
  endfunction

  function automatic logic is_perm(input logic [BW-1:0] v);
    logic [N-1:0] seen;
    int           x;
    seen = '0;
    for (int e = 0; e < N; e++) begin
      x = int'(v[e*W +: W]);
      if (x >= N) return 1'b0;
      seen[x] = 1'b1;
    end
    return &seen;
  endfunction

  // Start at a negedge; poke re-asserts start during cycle 'poke'.
  task automatic run(input logic [15:0] s, input int poke,
                     output logic [BW-1:0] res, output int lat,
                     output int npulse, output int late_busy);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    lat       = -1;
    npulse    = 0;
    late_busy = 0;
    res       = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == poke);
      if (c == 1) check("busy_rise", BW'(busy), BW'(1));
      if (done) begin
        npulse++;
        if (lat < 0) begin
          lat = c;
          res = data_out;
          check("busy_at_done", BW'(busy), BW'(0));
        end
      end else if (lat > 0 && busy) begin
        late_busy++;
      end
    end
    start = 1'b0;
  endtask

  logic [BW-1:0] r1;
  logic [BW-1:0] r2;
  int            lat;
  int            np;
  int            lb;
  int            stray;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || data_out !== identity()) stray++;
    end
    check("reset_data", data_out, identity());
    check("reset_busy", BW'(busy), BW'(0));
    check("reset_done", BW'(done), BW'(0));
    check("idle_quiet", BW'(stray), BW'(0));

    run(16'h0001, 0, r1, lat, np, lb);
    check("s1_latency", BW'(lat), BW'(32));
    check("s1_pulses", BW'(np), BW'(1));
    check("s1_model", r1, model(16'h0001));
    check("s1_perm", BW'(is_perm(r1)), BW'(1));
    check("s1_hold", data_out, r1);

`ifndef SHUFFLE_LFSR_FREERUN_EN
    run(16'h0000, 0, r1, lat, np, lb);
    run(16'hACE1, 0, r2, lat, np, lb);
    check("seed0_eq_default", r1, r2);
    check("default_model", r2, model(16'hACE1));
    check("default_perm", BW'(is_perm(r2)), BW'(1));
`endif

    run(16'h0001, 5, r1, lat, np, lb);
    check("poke_latency", BW'(lat), BW'(32));
    check("poke_pulses", BW'(np), BW'(1));
    check("poke_model", r1, model(16'h0001));

    run(16'h1234, 32, r1, lat, np, lb);
    check("at_done_ignored", BW'(lb), BW'(0));
    check("s1234_model", r1, model(16'h1234));

    @(negedge clk);
    seed  = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_data", data_out, identity());
    check("rst_mid_busy", BW'(busy), BW'(0));
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("rst_mid_nodone", BW'(stray), BW'(0));
    rst = 1'b1;
    run(16'h0001, 0, r1, lat, np, lb);
    check("rst_rerun_model", r1, model(16'h0001));
    check("rst_rerun_lat", BW'(lat), BW'(32));

`ifdef SHUFFLE_LFSR_FREERUN_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    run(16'h0000, 0, r1, lat, np, lb);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    run(16'h0000, 0, r2, lat, np, lb);
    check("freerun_differ", BW'(r1 != r2), BW'(1));
    check("freerun_perm_a", BW'(is_perm(r1)), BW'(1));
    check("freerun_perm_b", BW'(is_perm(r2)), BW'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
